// File: rtl/noobs_defs.sv
// Shared definitions for the NoobsCPU boot loader / memory dumper.
package noobs_defs;

  // Number of special-purpose addresses at the bottom of each data memory.
  localparam int unsigned DEF_DATA_OFFSET = 8;

  // Loader sequencing states.
  typedef enum logic [2:0] {
    ST_LOAD,
    ST_COOL,
    ST_RUN,
    ST_DUMP_RD,
    ST_DUMP_OUT,
    ST_DONE
  } state_t;

endpackage

// File: rtl/cool_counter.sv
// Loadable down-counter with a done flag, used for reset sequencing.
// done_o is high during the last enabled cycle of a loaded count.
module cool_counter #(
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             en_i,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: load has priority; stop at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = en_i && (cnt_q == CNT_W'(1));

endmodule

// File: rtl/mem_loader.sv
// Boot loader / memory dumper for the NoobsCPU system.
// Loads NUM_CH memory images from a byte stream, holds the CPU in reset
// through load and cool-off, then optionally streams a data memory back out.
// Optional feature macro: MEM_LOADER_DUMP_EN (dump path; RUN is terminal without it).
module mem_loader
  import noobs_defs::*;
#(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned DATA_OFFSET = DEF_DATA_OFFSET,
  parameter int unsigned COOL_CYCLES = 32,
  parameter int unsigned DUMP_CH     = 1,
  parameter int unsigned DUMP_START  = 8
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic [NUM_CH-1:0] mem_sel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              bus_own,
  output logic              cpu_reset_,
  output logic              load_done,
  output logic              ovf_err,
  input  logic              dump_req,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_last
);

  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned CNT_W = $clog2(COOL_CYCLES + 1);
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  state_t            state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              sready_q, sready_d;
  logic [NUM_CH-1:0] sel_q, sel_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wr_q, wr_d;
  logic              rd_q, rd_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;
  logic              beat, at_top, cnt_load, cnt_done;
`ifdef MEM_LOADER_DUMP_EN
  logic [ADDR_W-1:0] daddr_q, daddr_d;
  logic              dvalid_q, dvalid_d;
  logic [DATA_W-1:0] ddata_q, ddata_d;
  logic              dlast_q, dlast_d;
`endif

  cool_counter #(
    .CNT_W(CNT_W)
  ) u_cool (
    .clk_i     (clk),
    .reset_ni  (reset_),
    .load_i    (cnt_load),
    .load_val_i(CNT_W'(COOL_CYCLES)),
    .en_i      (state_q == ST_COOL),
    .done_o    (cnt_done)
  );

  assign beat   = s_valid && sready_q;
  assign at_top = (ptr_q == ADDR_MAX);

  // Next-state and registered-output computation.
  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    ptr_d    = ptr_q;
    sel_d    = '0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wr_d     = 1'b0;
    rd_d     = 1'b0;
    done_d   = done_q;
    ovf_d    = ovf_q;
    cnt_load = 1'b0;
`ifdef MEM_LOADER_DUMP_EN
    daddr_d  = daddr_q;
    dvalid_d = dvalid_q;
    ddata_d  = ddata_q;
    dlast_d  = dlast_q;
`endif
    case (state_q)
      ST_LOAD: begin
        if (beat) begin
          wr_d        = 1'b1;
          addr_d      = ptr_q;
          wdata_d     = s_data;
          sel_d[ch_q] = 1'b1;
          // Reaching the top address closes the image instead of wrapping.
          if (at_top && !s_last) ovf_d = 1'b1;
          if (s_last || at_top) begin
            if (ch_q == CH_W'(NUM_CH - 1)) begin
              state_d  = ST_COOL;
              done_d   = 1'b1;
              cnt_load = 1'b1;
            end else begin
              ch_d  = ch_q + CH_W'(1);
              ptr_d = ADDR_W'(DATA_OFFSET);
            end
          end else begin
            ptr_d = ptr_q + ADDR_W'(1);
          end
        end
      end
      ST_COOL: begin
        if (cnt_done) state_d = ST_RUN;
      end
`ifdef MEM_LOADER_DUMP_EN
      ST_RUN: begin
        if (dump_req) begin
          state_d        = ST_DUMP_RD;
          daddr_d        = ADDR_W'(DUMP_START);
          rd_d           = 1'b1;
          sel_d[DUMP_CH] = 1'b1;
          addr_d         = ADDR_W'(DUMP_START);
        end
      end
      ST_DUMP_RD: begin
        state_d = ST_DUMP_OUT;
      end
      // First DUMP_OUT cycle captures read data; later cycles wait for ready.
      ST_DUMP_OUT: begin
        if (!dvalid_q) begin
          dvalid_d = 1'b1;
          ddata_d  = mem_rdata;
          dlast_d  = (daddr_q == ADDR_MAX);
        end else if (dump_ready) begin
          dvalid_d = 1'b0;
          dlast_d  = 1'b0;
          if (dlast_q) begin
            state_d = ST_DONE;
          end else begin
            state_d        = ST_DUMP_RD;
            daddr_d        = daddr_q + ADDR_W'(1);
            rd_d           = 1'b1;
            sel_d[DUMP_CH] = 1'b1;
            addr_d         = daddr_q + ADDR_W'(1);
          end
        end
      end
`endif
      default: ;
    endcase
    sready_d = (state_d == ST_LOAD);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q  <= ST_LOAD;
      ch_q     <= '0;
      ptr_q    <= '0;
      sready_q <= 1'b0;
      sel_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      ptr_q    <= ptr_d;
      sready_q <= sready_d;
      sel_q    <= sel_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
    end
  end

`ifdef MEM_LOADER_DUMP_EN
  // Dump stream registers.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      daddr_q  <= '0;
      dvalid_q <= 1'b0;
      ddata_q  <= '0;
      dlast_q  <= 1'b0;
    end else begin
      daddr_q  <= daddr_d;
      dvalid_q <= dvalid_d;
      ddata_q  <= ddata_d;
      dlast_q  <= dlast_d;
    end
  end

  assign dump_valid = dvalid_q;
  assign dump_data  = ddata_q;
  assign dump_last  = dlast_q;
`else
  logic unused_dump;
  assign unused_dump = ^{dump_req, dump_ready, mem_rdata, DUMP_CH[0], DUMP_START[0]};
  assign dump_valid  = 1'b0;
  assign dump_data   = '0;
  assign dump_last   = 1'b0;
`endif

  assign s_ready    = sready_q;
  assign mem_sel    = sel_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_wr     = wr_q;
  assign mem_rd     = rd_q;
  assign load_done  = done_q;
  assign ovf_err    = ovf_q;
  assign cpu_reset_ = (state_q == ST_RUN);
  assign bus_own    = (state_q != ST_RUN);

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader: default instance (A) plus a 4-bit address
// instance (B) for the overflow case.
module tb_mem_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_;

  logic        a_s_valid, a_s_ready, a_s_last;
  logic [7:0]  a_s_data;
  logic [1:0]  a_sel;
  logic [11:0] a_addr;
  logic [7:0]  a_wdata;
  logic [7:0]  a_rdata = '0;
  logic        a_wr, a_rd, a_bus, a_cpu, a_done, a_ovf;
  logic        a_dreq, a_dvalid, a_dready, a_dlast;
  logic [7:0]  a_ddata;

  logic        b_s_valid, b_s_ready, b_s_last;
  logic [7:0]  b_s_data;
  logic [1:0]  b_sel;
  logic [3:0]  b_addr;
  logic [7:0]  b_wdata;
  logic [7:0]  b_rdata = '0;
  logic        b_wr, b_rd, b_bus, b_cpu, b_done, b_ovf;
  logic        b_dreq = 1'b0;
  logic        b_dready = 1'b0;
  logic        b_dvalid, b_dlast;
  logic [7:0]  b_ddata;

  int tests = 0;
  int fails = 0;
  int nbytes, bad;
  logic [11:0] exp_a;
  logic saw_last;

  mem_loader u_a (
    .clk(clk), .reset_(reset_),
    .s_valid(a_s_valid), .s_ready(a_s_ready), .s_data(a_s_data), .s_last(a_s_last),
    .mem_sel(a_sel), .mem_addr(a_addr), .mem_wdata(a_wdata), .mem_wr(a_wr), .mem_rd(a_rd),
    .mem_rdata(a_rdata), .bus_own(a_bus), .cpu_reset_(a_cpu), .load_done(a_done),
    .ovf_err(a_ovf), .dump_req(a_dreq), .dump_valid(a_dvalid), .dump_ready(a_dready),
    .dump_data(a_ddata), .dump_last(a_dlast)
  );

  mem_loader #(
    .ADDR_W(4),
    .COOL_CYCLES(4)
  ) u_b (
    .clk(clk), .reset_(reset_),
    .s_valid(b_s_valid), .s_ready(b_s_ready), .s_data(b_s_data), .s_last(b_s_last),
    .mem_sel(b_sel), .mem_addr(b_addr), .mem_wdata(b_wdata), .mem_wr(b_wr), .mem_rd(b_rd),
    .mem_rdata(b_rdata), .bus_own(b_bus), .cpu_reset_(b_cpu), .load_done(b_done),
    .ovf_err(b_ovf), .dump_req(b_dreq), .dump_valid(b_dvalid), .dump_ready(b_dready),
    .dump_data(b_ddata), .dump_last(b_dlast)
  );

  // Expected channel-1 contents: loaded bytes at 8/9, fixed pattern elsewhere.
  function automatic logic [7:0] mem_at(input logic [11:0] a);
    if (a == 12'd8) return 8'hAA;
    if (a == 12'd9) return 8'hBB;
    return a[7:0] ^ 8'h5A;
  endfunction

  // Synchronous-read memory model for channel 1 of instance A.
  always @(posedge clk) begin
    if (a_rd && a_sel == 2'b10) a_rdata <= mem_at(a_addr);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_ = 1'b0;
    a_s_valid = 1'b0; a_s_data = '0; a_s_last = 1'b0; a_dreq = 1'b0; a_dready = 1'b0;
    b_s_valid = 1'b0; b_s_data = '0; b_s_last = 1'b0;
    repeat (2) @(negedge clk);

    // Reset values
    chk("rst_s_ready", 32'(a_s_ready), 0);
    chk("rst_wr_rd_sel", 32'({a_wr, a_rd, a_sel}), 0);
    chk("rst_addr_wdata", 32'({a_addr, a_wdata}), 0);
    chk("rst_bus_cpu", 32'({a_bus, a_cpu}), 32'b10);
    chk("rst_done_ovf", 32'({a_done, a_ovf}), 0);
    chk("rst_dump", 32'({a_dvalid, a_dlast, a_ddata}), 0);

    reset_ = 1'b1;
    @(negedge clk);
    chk("s_ready_up", 32'(a_s_ready), 1);

    // Channel 0: back-to-back beats
    a_s_valid = 1'b1; a_s_data = 8'h01; a_s_last = 1'b0;
    @(negedge clk);
    chk("w0", 32'({a_wr, a_sel, a_addr, a_wdata}), 32'({1'b1, 2'b01, 12'd0, 8'h01}));
    a_s_data = 8'h02;
    @(negedge clk);
    chk("w1", 32'({a_wr, a_sel, a_addr, a_wdata}), 32'({1'b1, 2'b01, 12'd1, 8'h02}));
    a_s_data = 8'h03; a_s_last = 1'b1;
    @(negedge clk);
    chk("w2", 32'({a_wr, a_sel, a_addr, a_wdata}), 32'({1'b1, 2'b01, 12'd2, 8'h03}));
    chk("done_after_ch0", 32'(a_done), 0);

    // Channel 1: s_valid toggling
    a_s_valid = 1'b0; a_s_last = 1'b0;
    @(negedge clk);
    chk("gap0_nowr", 32'(a_wr), 0);
    a_s_valid = 1'b1; a_s_data = 8'hAA;
    @(negedge clk);
    chk("w8", 32'({a_wr, a_sel, a_addr, a_wdata}), 32'({1'b1, 2'b10, 12'd8, 8'hAA}));
    a_s_valid = 1'b0;
    @(negedge clk);
    chk("gap1_nowr", 32'(a_wr), 0);
    a_s_valid = 1'b1; a_s_data = 8'hBB; a_s_last = 1'b1;
    @(negedge clk);
    chk("w9", 32'({a_wr, a_sel, a_addr, a_wdata}), 32'({1'b1, 2'b10, 12'd9, 8'hBB}));
    chk("load_done", 32'(a_done), 1);
    chk("s_ready_cool", 32'(a_s_ready), 0);
    a_s_valid = 1'b0; a_s_last = 1'b0;

    // Cool-off: cpu_reset_ rises 32 cycles after load_done
    repeat (31) @(negedge clk);
    chk("cool_cpu_held", 32'({a_cpu, a_bus}), 32'b01);
    @(negedge clk);
    chk("run_cpu_bus", 32'({a_cpu, a_bus}), 32'b10);
    chk("ovf_clear", 32'(a_ovf), 0);

`ifdef MEM_LOADER_DUMP_EN
    a_dreq = 1'b1; a_dready = 1'b0;
    @(negedge clk);
    chk("dump_rd", 32'({a_rd, a_sel, a_addr}), 32'({1'b1, 2'b10, 12'd8}));
    chk("dump_cpu_bus", 32'({a_cpu, a_bus}), 32'b01);
    a_dreq = 1'b0;
    @(negedge clk);
    chk("dump_capture", 32'({a_dvalid, a_rd}), 0);
    @(negedge clk);
    chk("dump_first", 32'({a_dvalid, a_ddata}), 32'({1'b1, 8'hAA}));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("dump_hold", 32'({a_dvalid, a_ddata, a_rd}), 32'({1'b1, 8'hAA, 1'b0}));
    end
    a_dready = 1'b1;
    exp_a = 12'd8; nbytes = 0; bad = 0; saw_last = 1'b0;
    for (int c = 0; c < 20000; c++) begin
      if (a_dvalid) begin
        if (a_ddata !== mem_at(exp_a) || a_dlast !== (exp_a == 12'hFFF)) bad++;
        nbytes++;
        if (exp_a == 12'hFFF) saw_last = 1'b1;
        exp_a = exp_a + 12'd1;
      end
      @(negedge clk);
      if (saw_last) break;
    end
    chk("dump_count", 32'(nbytes), 4088);
    chk("dump_bad", 32'(bad), 0);
    chk("dump_saw_last", 32'(saw_last), 1);
    chk("done_state", 32'({a_cpu, a_bus, a_dvalid, a_rd, a_wr, a_sel}), 32'b0100000);
    a_dready = 1'b0;
    repeat (3) @(negedge clk);
    chk("done_terminal", 32'({a_cpu, a_bus, a_dvalid}), 32'b010);
`else
    a_dreq = 1'b1; a_dready = 1'b1;
    repeat (4) @(negedge clk);
    chk("nodump_cpu_bus", 32'({a_cpu, a_bus}), 32'b10);
    chk("nodump_strobes", 32'({a_dvalid, a_rd, a_sel}), 0);
    a_dreq = 1'b0; a_dready = 1'b0;
`endif

    // Reset during channel 1 load
    reset_ = 1'b0;
    @(negedge clk);
    reset_ = 1'b1;
    @(negedge clk);
    a_s_valid = 1'b1; a_s_data = 8'h11; a_s_last = 1'b1;
    @(negedge clk);
    chk("rl_w0", 32'({a_wr, a_sel, a_addr, a_wdata}), 32'({1'b1, 2'b01, 12'd0, 8'h11}));
    a_s_data = 8'h22; a_s_last = 1'b0;
    @(negedge clk);
    chk("rl_w8", 32'({a_wr, a_sel, a_addr, a_wdata}), 32'({1'b1, 2'b10, 12'd8, 8'h22}));
    reset_ = 1'b0;
    #1;
    chk("abort_wr", 32'({a_wr, a_sel, a_addr, a_wdata}), 0);
    chk("abort_ctl", 32'({a_s_ready, a_done, a_bus, a_cpu}), 32'b0010);
    a_s_valid = 1'b0;
    @(negedge clk);
    reset_ = 1'b1;
    @(negedge clk);
    chk("reload_ready", 32'(a_s_ready), 1);
    a_s_valid = 1'b1; a_s_data = 8'h44; a_s_last = 1'b0;
    @(negedge clk);
    chk("reload_w0", 32'({a_wr, a_sel, a_addr, a_wdata}), 32'({1'b1, 2'b01, 12'd0, 8'h44}));
    a_s_valid = 1'b0;

    // Overflow on instance B (ADDR_W=4)
    reset_ = 1'b0;
    @(negedge clk);
    reset_ = 1'b1;
    @(negedge clk);
    chk("b_ready", 32'(b_s_ready), 1);
    b_s_valid = 1'b1; b_s_data = 8'h5A; b_s_last = 1'b1;
    @(negedge clk);
    chk("b_w0", 32'({b_wr, b_sel, b_addr, b_wdata}), 32'({1'b1, 2'b01, 4'd0, 8'h5A}));
    b_s_data = 8'h10; b_s_last = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("b_ovf_w", 32'({b_wr, b_sel, b_addr, b_wdata}),
          32'({1'b1, 2'b10, 4'(8 + i), 8'(8'h10 + i)}));
      chk("b_ovf_flag", 32'(b_ovf), 32'(i == 7));
      b_s_data = 8'(8'h11 + i);
    end
    chk("b_done", 32'(b_done), 1);
    chk("b_ready_low", 32'(b_s_ready), 0);
    @(negedge clk);
    chk("b_ninth_dropped", 32'(b_wr), 0);
    chk("b_ovf_sticky", 32'(b_ovf), 1);
    b_s_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_loader.md
# mem_loader

Synthesizable boot loader and memory dumper for the NoobsCPU system. It takes a byte stream and writes it into NUM_CH memory images in order: channel 0 is instruction memory, channels ≥1 are data memories. It holds the CPU in reset through loading plus a cool-off period. On request, it streams a data-memory region back out. It sits between the host/stream source and the memory mux that feeds `data_mem` instances and `noobs_cpu`.

## Interface
- ADDR_W, 12, memory address width
- DATA_W, 8, byte/word width
- NUM_CH, 2, number of memory images loaded, in index order
- DATA_OFFSET, 8, load base address for channels ≥1 (first 8 addresses are special-purpose); channel 0 loads from 0
- COOL_CYCLES, 32, cycles between load completion and CPU reset release (≥1)
- DUMP_CH, 1, channel read back by dump
- DUMP_START, 8, first dumped address

- clk  in  1  system clock, rising edge
- reset_  in  1  asynchronous, active-low reset
- s_valid / s_ready  in/out  1  load stream handshake
- s_data  in  DATA_W  load byte
- s_last  in  1  final byte of current channel image
- mem_sel  out  NUM_CH  one-hot target memory; 0 when idle
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  write data
- mem_wr / mem_rd  out  1  write / read strobe
- mem_rdata  in  DATA_W  read data of selected memory, 1-cycle latency
- bus_own  out  1  loader owns memory bus; external mux gives CPU the bus when 0
- cpu_reset_  out  1  active-low CPU reset
- load_done  out  1  all channels loaded
- ovf_err  out  1  sticky: an image hit top of address space without s_last
- dump_req  in  1  level; sampled in RUN
- dump_valid / dump_ready  out/in  1  dump stream handshake
- dump_data  out  DATA_W  dumped byte
- dump_last  out  1  marks address 2^ADDR_W−1

## Operation
- States: LOAD → COOL → RUN → DUMP_RD ↔ DUMP_OUT → DONE.
- LOAD:
  - s_ready=1. ch starts at 0.
  - Each accepted beat writes to `ch` at `ptr`. ptr starts at 0 for ch 0 and DATA_OFFSET otherwise.
  - ptr increments after each beat.
  - s_last on ch<NUM_CH−1 advances ch and reloads ptr.
  - s_last on the last channel enters COOL and sets load_done.
  - Each channel carries at least 1 byte.
- Overflow: a beat accepted at ptr=2^ADDR_W−1 without s_last is treated as last. ovf_err is set and ptr does not wrap.
- COOL: s_ready=0. A counter runs COOL_CYCLES cycles, then the block enters RUN.
- RUN: cpu_reset_=1, bus_own=0. dump_req=1 enters DUMP_RD with daddr=DUMP_START and cpu_reset_ driven 0.
- DUMP_RD: one cycle. mem_rd=1, mem_sel=DUMP_CH, mem_addr=daddr.
- DUMP_OUT:
  - Registered mem_rdata is presented with dump_valid=1 and held stable until dump_ready.
  - On handshake, daddr increments and the block returns to DUMP_RD.
  - The handshake with dump_last=1 enters DONE.
- DONE: terminal. cpu_reset_=0, bus_own=1, no strobes. Only reset_ exits.
- dump_req outside RUN is ignored.

## Timing
- Reset values:
  - Outputs: s_ready=0, mem_sel=0, mem_addr=0, mem_wdata=0, mem_wr=0, mem_rd=0, bus_own=1, cpu_reset_=0, load_done=0, ovf_err=0, dump_valid=0, dump_data=0, dump_last=0.
  - Internal state: LOAD, ch=0.
- s_ready rises the first cycle after reset_ deasserts.
- Write latency: beat accepted at edge k produces registered mem_wr=1 with addr/data/sel during cycle k+1. Back-to-back beats give one write per cycle.
- cpu_reset_ rises exactly COOL_CYCLES cycles after the edge on which load_done rises.
- Dump throughput: at most 1 byte per 2 cycles. dump_valid first asserts 2 cycles after the edge that samples dump_req.
- reset_ mid-load or mid-dump aborts immediately and returns to reset values. Partial memory contents are not cleared.

## Configuration
- MEM_LOADER_DUMP_EN defined: DUMP_RD/DUMP_OUT/DONE and the dump ports are functional.
- MEM_LOADER_DUMP_EN undefined: RUN is terminal, dump_req is ignored, and dump_valid/dump_data/dump_last are tied 0. Ports remain for a stable interface.

## Structure
- Shared package/header `noobs_defs`: state encoding localparams, and DATA_OFFSET default of 8 (special-purpose address count).
- Sub-module `cool_counter`: loadable down-counter with a done flag, reusable for other reset sequencing.

## Test plan
- Default parameters, ch0 image 3 bytes {01,02,03 last}, ch1 image 2 bytes {AA,BB last} -> writes sel=01 to addr 0,1,2, then sel=10 to addr 8,9. load_done after BB. cpu_reset_ high 32 cycles later.
- s_valid toggling every other cycle -> every write issued one cycle after its accept, with no lost or duplicated writes.
- ADDR_W=4, ch1 stream of 9 bytes with no s_last, from offset 8 -> 8 writes at addr 8..15. 8th accepted as last, ovf_err=1, 9th beat not accepted (s_ready=0).
- After RUN, dump_req=1 with dump_ready held 0 for 5 cycles -> dump_data at addr 8 stable, dump_valid held. Bytes then stream through addr 0xFFF. dump_last on 0xFFF, then DONE.
- reset_ asserted during ch1 load -> all outputs at reset values immediately. A reload restarts from ch0 addr 0.
- MEM_LOADER_DUMP_EN undefined, dump_req=1 in RUN -> cpu_reset_ stays 1, bus_own=0, dump_valid=0.
